calc_cmd_driver: RTL and testbench

Command-side driver for the calculator datapath: accepts a stream of (op_code, operand) commands over a valid/ready handshake and buffers them in a small FIFO. It presents each command to the calculator's `op_code`/`input1` port for a fixed number of cycles, then samples `output1`/`err_code`. Each result is returned in order over a valid/ready response channel. It sits between the test/host logic and the accumulator-based calculator, owning all sequencing of that interface.

---
 rtl/calc_pkg.sv | 33 +++
 rtl/calc_cmd_fifo.sv | 55 +++++
 rtl/calc_cmd_driver.sv | 115 +++++++++++
 tb/tb_calc_cmd_driver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - opcode, error code and FSM state definitions shared by the calculator driver
package calc_pkg;

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_MUL     = 4'd2;
  localparam logic [3:0] OP_DIV     = 4'd3;
  localparam logic [3:0] OP_MOD     = 4'd4;
  localparam logic [3:0] OP_AND     = 4'd5;
  localparam logic [3:0] OP_OR      = 4'd6;
  localparam logic [3:0] OP_NAND    = 4'd7;
  localparam logic [3:0] OP_NOR     = 4'd8;
  localparam logic [3:0] OP_XOR     = 4'd9;
  localparam logic [3:0] OP_XNOR    = 4'd10;
  localparam logic [3:0] OP_NOT     = 4'd11;
  localparam logic [3:0] OP_PRESET  = 4'd12;
  localparam logic [3:0] OP_CLEAR   = 4'd13;
  localparam logic [3:0] OP_HOLD    = 4'd14;
  localparam logic [3:0] OP_ILLEGAL = 4'd15;

  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return op == OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// rtl/calc_cmd_fifo.sv - synchronous show-ahead command FIFO with full/empty flags
module calc_cmd_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/calc_cmd_driver.sv
// rtl/calc_cmd_driver.sv - queues calculator commands, sequences the ALU port and returns results in order
module calc_cmd_driver
  import calc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RES_W  = 32,
  parameter int LAT    = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0]        rsp_op,
  output logic [RES_W-1:0]  rsp_result,
  output logic [1:0]        rsp_err,
  output logic [3:0]        alu_op_code,
  output logic [DATA_W-1:0] alu_input1,
  input  logic [RES_W-1:0]  alu_output1,
  input  logic [1:0]        alu_err_code,
  output logic              busy
);

  localparam int ENTRY_W = 4 + DATA_W;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          cnt;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [ENTRY_W-1:0]  head;
  logic [3:0]          head_op;
  logic [DATA_W-1:0]   head_data;

  assign {head_op, head_data} = head;
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  // A pop happens whenever the FSM is free to start the next command.
  assign pop       = !empty && (state == IDLE || (state == RESP && rsp_ready));

  calc_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({cmd_op, cmd_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (pop) begin
      state_nxt = is_illegal(head_op) ? RESP : DRIVE;
    end else begin
      case (state)
        DRIVE:   if (cnt == '0) state_nxt = RESP;
        RESP:    if (rsp_ready) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    rsp_valid = state == RESP;
    busy      = (state != IDLE) || !empty;
  end

  // Response fields only change on a pop, which in RESP needs rsp_ready, so they hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      alu_op_code <= OP_HOLD;
      alu_input1  <= '0;
      rsp_op      <= '0;
      rsp_result  <= '0;
      rsp_err     <= '0;
    end else if (pop) begin
      if (is_illegal(head_op)) begin
        rsp_op     <= head_op;
        rsp_result <= '0;
        rsp_err    <= ERR_ILLEGAL;
      end else begin
        alu_op_code <= head_op;
        alu_input1  <= head_data;
        cnt         <= 4'(LAT - 1);
      end
    end else if (state == DRIVE) begin
      if (cnt == '0) begin
        rsp_op      <= alu_op_code;
        rsp_result  <= alu_output1;
        rsp_err     <= alu_err_code;
        alu_op_code <= OP_HOLD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calc_cmd_driver.sv
// tb/tb_calc_cmd_driver.sv - scoreboard bench for calc_cmd_driver with a registered calculator stub
module tb_calc_cmd_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_op;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_err;
  logic [3:0]  alu_op_code;
  logic [15:0] alu_input1;
  logic [31:0] alu_output1;
  logic [1:0]  alu_err_code;
  logic        busy;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] result;
    logic [1:0]  err;
  } exp_t;

  exp_t exp_q [$];
  int   hs_cyc [$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   rsp_cnt = 0;
  logic watch_alu = 1'b0;
  logic alu_moved = 1'b0;

  calc_cmd_driver #(
    .DATA_W (16),
    .RES_W  (32),
    .LAT    (2),
    .DEPTH  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_op       (rsp_op),
    .rsp_result   (rsp_result),
    .rsp_err      (rsp_err),
    .alu_op_code  (alu_op_code),
    .alu_input1   (alu_input1),
    .alu_output1  (alu_output1),
    .alu_err_code (alu_err_code),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Calculator stub: registered echo of the drive, divide-by-zero error on op 3 with operand 0.
  always @(posedge clk) begin
    alu_output1  <= {alu_op_code, 12'h000, alu_input1};
    alu_err_code <= (alu_op_code == 4'd3 && alu_input1 == 16'd0) ? 2'b10 : 2'b00;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] data);
    exp_t e;
    e.op = op;
    if (op == 4'd15) begin
      e.result = 32'h0;
      e.err    = 2'b11;
    end else begin
      e.result = {op, 12'h000, data};
      e.err    = (op == 4'd3 && data == 16'd0) ? 2'b10 : 2'b00;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_op, cmd_data));
      if (rsp_valid && rsp_ready) begin
        hs_cyc.push_back(cyc);
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", {28'h0, rsp_op}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("rsp_op", {28'h0, rsp_op}, {28'h0, e.op});
          check_eq("rsp_result", rsp_result, e.result);
          check_eq("rsp_err", {30'h0, rsp_err}, {30'h0, e.err});
        end
      end
      if (watch_alu && alu_op_code != 4'd14) alu_moved = 1'b1;
    end
  end

  task automatic send(input logic [3:0] op, input logic [15:0] data);
    int n;
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 100) begin
        check_eq("send_stall", {31'h0, cmd_ready}, 32'h1);
        break;
      end
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    check_eq("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    cmd_data  = 16'd0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("rst_rsp_op", {28'h0, rsp_op}, 32'h0);
    check_eq("rst_rsp_result", rsp_result, 32'h0);
    check_eq("rst_rsp_err", {30'h0, rsp_err}, 32'h0);
    check_eq("rst_alu_op", {28'h0, alu_op_code}, 32'd14);
    check_eq("rst_alu_in", {16'h0, alu_input1}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;

    // Single command and its latency from acceptance.
    rsp_ready = 1'b1;
    send(4'd0, 16'd11);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        k = i;
        break;
      end
    end
    check_eq("latency", k, 3);
    check_eq("single_result", rsp_result, 32'h0000_000B);
    drain();

    // Illegal opcode never touches the ALU.
    watch_alu = 1'b1;
    send(4'd15, 16'd5);
    drain();
    watch_alu = 1'b0;
    check_eq("illegal_alu_idle", {31'h0, alu_moved}, 32'h0);

    // Backpressure: one command parked in RESP, four in the FIFO.
    rsp_ready = 1'b0;
    n0 = rsp_cnt;
    send(4'd1, 16'd1);
    send(4'd2, 16'd2);
    send(4'd3, 16'd0);
    send(4'd4, 16'd4);
    send(4'd5, 16'd5);
    repeat (2) @(posedge clk);
    #1;
    check_eq("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    check_eq("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check_eq("bp_hold_result0", rsp_result, 32'h1000_0001);
    repeat (3) @(posedge clk);
    #1;
    check_eq("bp_hold_result1", rsp_result, 32'h1000_0001);
    check_eq("bp_hold_op", {28'h0, rsp_op}, 32'h1);
    check_eq("bp_hold_valid", {31'h0, rsp_valid}, 32'h1);
    rsp_ready = 1'b1;
    drain();
    check_eq("bp_rsp_count", rsp_cnt - n0, 5);

    // Back-to-back throughput.
    hs_cyc.delete();
    for (int i = 0; i < 8; i++) send(4'(i), 16'($urandom));
    drain();
    check_eq("b2b_count", hs_cyc.size(), 8);
    for (int i = 1; i < hs_cyc.size(); i++) check_eq("b2b_spacing", hs_cyc[i] - hs_cyc[i-1], 3);

    // Reset while the ALU is being driven, with two entries queued.
    send(4'd2, 16'd7);
    send(4'd4, 16'd9);
    send(4'd6, 16'd3);
    check_eq("mid_alu_op", {28'h0, alu_op_code}, 32'd2);
    check_eq("mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n0 = rsp_cnt;
    repeat (20) @(posedge clk);
    #1;
    check_eq("post_rst_rsp_count", rsp_cnt - n0, 0);
    check_eq("post_rst_busy", {31'h0, busy}, 32'h0);
    check_eq("post_rst_alu_op", {28'h0, alu_op_code}, 32'd14);
    check_eq("post_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
